// File: rtl/loader_pkg.sv
// Shared state encoding and error codes for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ZERO_LEN = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/loader_timer.sv
// Idle watchdog: counts cycles without a transfer and flags when TIMEOUT of them
// have elapsed since the last clear.
module loader_timer
  import loader_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // The TIMEOUT-th idle cycle is the one that sees the count at TIMEOUT-1.
  assign expired = enable && !clear && (r_count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear || expired) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed, checksummed program image into memory and
// releases the processor only after the checksum verifies.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              cpu_run,
  output logic              err,
  output logic [1:0]        err_code
);

  state_t r_state;
  state_t w_next;

  logic              w_ready;
  logic              w_accept;
  logic              w_enter_len;
  logic              w_set_err;
  logic [1:0]        w_err_value;
  logic              w_clear;
  logic              w_expired;

  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_remaining;
  logic [7:0]        r_sum;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_data;
  logic              r_mem_we;
  logic [1:0]        r_err_code;

  assign w_ready  = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_accept = in_valid && w_ready;
  assign w_clear  = w_accept || w_enter_len;

  loader_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_clear),
    .enable  (w_ready),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_enter_len = 1'b0;
    w_set_err   = 1'b0;
    w_err_value = ERR_NONE;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          w_next      = S_LEN;
          w_enter_len = 1'b1;
        end
      end
      S_LEN: begin
        if (w_accept) begin
          if (in_data == 8'd0) begin
            w_next      = S_ERR;
            w_set_err   = 1'b1;
            w_err_value = ERR_ZERO_LEN;
          end else begin
            w_next = S_DATA;
          end
        end else if (w_expired) begin
          w_next      = S_ERR;
          w_set_err   = 1'b1;
          w_err_value = ERR_TIMEOUT;
        end
      end
      S_DATA: begin
        if (w_accept) begin
          if (r_remaining == 8'd1) begin
            w_next = S_CSUM;
          end
        end else if (w_expired) begin
          w_next      = S_ERR;
          w_set_err   = 1'b1;
          w_err_value = ERR_TIMEOUT;
        end
      end
      S_CSUM: begin
        if (w_accept) begin
          if (in_data == r_sum) begin
            w_next = S_DONE;
          end else begin
            w_next      = S_ERR;
            w_set_err   = 1'b1;
            w_err_value = ERR_CHECKSUM;
          end
        end else if (w_expired) begin
          w_next      = S_ERR;
          w_set_err   = 1'b1;
          w_err_value = ERR_TIMEOUT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Only payload bytes produce a write; length and checksum bytes just steer the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_remaining <= 8'd0;
      r_sum       <= 8'd0;
      r_mem_addr  <= '0;
      r_mem_data  <= 8'd0;
      r_mem_we    <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_mem_we <= 1'b0;
      if (w_enter_len) begin
        r_addr     <= '0;
        r_sum      <= 8'd0;
        r_err_code <= ERR_NONE;
      end
      if (w_set_err) begin
        r_err_code <= w_err_value;
      end
      if (w_accept) begin
        case (r_state)
          S_LEN: r_remaining <= in_data;
          S_DATA: begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_data  <= in_data;
            r_addr      <= r_addr + ADDR_W'(1);
            r_sum       <= r_sum + in_data;
            r_remaining <= r_remaining - 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready = w_ready;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign mem_we   = r_mem_we;
  assign cpu_run  = (r_state == S_DONE);
  assign err      = (r_state == S_ERR);
  assign err_code = r_err_code;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: vector table, hand-written corner
// sequences and random streams judged by a stream-level reference model.
module tb_program_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_we;
  logic       cpu_run;
  logic       err;
  logic [1:0] err_code;

  int nChecks = 0;
  int nFails  = 0;

  logic [15:0] gotW[$];
  logic [15:0] expW[$];

  typedef struct {
    logic [47:0] bytes;
    int          len;
    int          expCode;
    int          expWrites;
  } vecT;

  localparam int NVEC = 6;
  vecT vecs[NVEC];

  program_loader #(
    .ADDR_W  (8),
    .TIMEOUT (255)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_we   (mem_we),
    .cpu_run  (cpu_run),
    .err      (err),
    .err_code (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) gotW.push_back({mem_addr, mem_data});
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Stream rules: N, N payload bytes to addresses 0..N-1, then modulo-256 sum.
  function automatic int modelLoad(input logic [7:0] s[$]);
    int n;
    int total;
    expW.delete();
    if (s.size() == 0) return 3;
    n = s[0];
    if (n == 0) return 1;
    total = 0;
    for (int k = 0; k < n; k++) begin
      if (k + 1 >= s.size()) return 3;
      expW.push_back({8'(k), s[k+1]});
      total = total + s[k+1];
    end
    if (n + 1 >= s.size()) return 3;
    return (s[n+1] == 8'(total % 256)) ? 0 : 2;
  endfunction

  task automatic applyStimulus(input logic [7:0] s[$], input int minGap, input int maxGap,
                               input int startAt);
    int n;
    int gap;
    n = s[0];
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < s.size(); i++) begin
      gap = (maxGap > minGap) ? int'($urandom_range(maxGap, minGap)) : minGap;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = s[i];
      if (!in_ready) break;
      if (i == startAt) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("we_after_byte", int'(mem_we), int'(i >= 1 && i <= n));
    end
    in_valid = 1'b0;
  endtask

  task automatic waitOutcome();
    int cyc;
    cyc = 0;
    while (!(cpu_run || err) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    nChecks++;
    if (!(cpu_run || err)) begin
      nFails++;
      $display("[TB] FAIL outcome_wait: no DONE/ERR after %0d cycles, required within 400", cyc);
    end
  endtask

  task automatic checkResult(input int expCode, input int expWrites, input int base);
    checkOutput("cpu_run", int'(cpu_run), int'(expCode == 0));
    checkOutput("err", int'(err), int'(expCode != 0));
    checkOutput("err_code", int'(err_code), expCode);
    checkOutput("write_count", gotW.size() - base, expWrites);
    for (int k = 0; k < expW.size() && base + k < gotW.size(); k++)
      checkOutput("write_word", int'(gotW[base+k]), int'(expW[k]));
  endtask

  initial begin
    logic [7:0] q[$];
    int base;
    int code;
    int n;
    int total;

    // 0x16 is the modulo-256 sum of A1,B2,C3, so 0x36 must be rejected.
    vecs[0] = '{bytes: 48'h03A1B2C31600, len: 5, expCode: 0, expWrites: 3};
    vecs[1] = '{bytes: 48'h03A1B2C33600, len: 5, expCode: 2, expWrites: 3};
    vecs[2] = '{bytes: 48'h021020310000, len: 4, expCode: 2, expWrites: 2};
    vecs[3] = '{bytes: 48'h005500000000, len: 2, expCode: 1, expWrites: 0};
    vecs[4] = '{bytes: 48'h01FFFF000000, len: 3, expCode: 0, expWrites: 1};
    vecs[5] = '{bytes: 48'h040102000000, len: 3, expCode: 3, expWrites: 2};

    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    checkOutput("reset_in_ready", int'(in_ready), 0);
    checkOutput("reset_mem_we", int'(mem_we), 0);
    checkOutput("reset_mem_addr", int'(mem_addr), 0);
    checkOutput("reset_mem_data", int'(mem_data), 0);
    checkOutput("reset_cpu_run", int'(cpu_run), 0);
    checkOutput("reset_err", int'(err), 0);
    checkOutput("reset_err_code", int'(err_code), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < NVEC; v++) begin
      q.delete();
      for (int i = 0; i < vecs[v].len; i++) q.push_back(vecs[v].bytes[47-8*i -: 8]);
      void'(modelLoad(q));
      base = gotW.size();
      applyStimulus(q, 0, 2, -1);
      waitOutcome();
      checkResult(vecs[v].expCode, vecs[v].expWrites, base);
    end

    // Timeout boundary: 254 idle cycles are tolerated, the 255th aborts.
    q = {8'h04, 8'h01, 8'h02};
    void'(modelLoad(q));
    base = gotW.size();
    applyStimulus(q, 0, 0, -1);
    repeat (254) @(negedge clk);
    checkOutput("timeout_not_yet", int'(err), 0);
    @(negedge clk);
    checkResult(3, 2, base);

    // Reset in the middle of a payload abandons the load.
    q = {8'h04, 8'h11, 8'h22};
    base = gotW.size();
    applyStimulus(q, 0, 0, -1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", int'(in_ready), 0);
    checkOutput("midrst_mem_we", int'(mem_we), 0);
    checkOutput("midrst_mem_addr", int'(mem_addr), 0);
    checkOutput("midrst_mem_data", int'(mem_data), 0);
    checkOutput("midrst_cpu_run", int'(cpu_run), 0);
    checkOutput("midrst_err", int'(err), 0);
    checkOutput("midrst_err_code", int'(err_code), 0);
    in_valid = 1'b1;
    in_data  = 8'h33;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midrst_writes", gotW.size() - base, 2);
    checkOutput("midrst_idle_ready", int'(in_ready), 0);
    in_valid = 1'b0;
    q = {8'h01, 8'hFF, 8'hFF};
    code = modelLoad(q);
    base = gotW.size();
    applyStimulus(q, 0, 0, -1);
    waitOutcome();
    checkResult(code, expW.size(), base);

    // A start pulse during the payload must not restart the load.
    q = {8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h16};
    code = modelLoad(q);
    base = gotW.size();
    applyStimulus(q, 0, 0, 2);
    waitOutcome();
    checkResult(code, expW.size(), base);

    // in_valid while not ready is ignored.
    base = gotW.size();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    checkOutput("notready_writes", gotW.size() - base, 0);
    checkOutput("notready_cpu_run", int'(cpu_run), 1);
    checkOutput("notready_in_ready", int'(in_ready), 0);

    // The reference stream with random gaps, including one maximal gap.
    q = {8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h16};
    for (int r = 0; r < 5; r++) begin
      code = modelLoad(q);
      base = gotW.size();
      if (r == 0) applyStimulus(q, 254, 254, -1);
      else applyStimulus(q, 0, 40, -1);
      waitOutcome();
      checkResult(code, expW.size(), base);
    end

    // Random streams with good or corrupted checksums.
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(8, 1);
      q.delete();
      q.push_back(8'(n));
      total = 0;
      for (int k = 0; k < n; k++) begin
        q.push_back(8'($urandom));
        total = total + q[k+1];
      end
      if ($urandom_range(1, 0) == 1) q.push_back(8'(total % 256));
      else q.push_back(8'((total + $urandom_range(255, 1)) % 256));
      code = modelLoad(q);
      base = gotW.size();
      applyStimulus(q, 0, 6, -1);
      waitOutcome();
      checkResult(code, expW.size(), base);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
